// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-buffered UART transmitter:
//   - parity mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - transmit FSM state type tx_state_t
//   - calc_div(): bit period in clock cycles, rounded to nearest
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Round-to-nearest division so e.g. 100 MHz / 921600 gives 109, not 108.
    function automatic int calc_div(input longint clk_freq, input longint baud);
        return int'((clk_freq + (baud / 2)) / baud);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..DIV-1 while enabled and wraps; bit_tick marks
// the last cycle of each bit period.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   clear    in   restart the bit period (counter to 0 on this edge)
//   enable   in   count while high, hold while low
//   bit_tick out  high during the final cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 921_600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_baud_gen: CLK_FREQ/BAUD must give a bit period of at least 2 cycles");
    end

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        end
    end

    assign bit_tick = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Parametrised UART transmitter with an internal transmit FIFO. Upstream
// logic queues words through a valid/ready interface; the FSM drains the
// FIFO and serialises frames (start, data LSB first, optional parity, stop)
// onto a registered TxD line. Consecutive queued words go out with no idle
// gap between frames.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   tx_valid   in   write request
//   tx_data    in   word to send (DATA_BITS wide)
//   tx_ready   out  FIFO not full; write accepted when tx_valid & tx_ready
//   txd        out  serial line, registered, idle high
//   tx_busy    out  frame in progress or FIFO non-empty
//   fifo_count out  entries currently queued
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 921_600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~(^d) : ^d;
    endfunction

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          count_q, count_d;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    tx_state_t            state_q;
    logic                 bit_tick;
    logic                 stop_idx_q;

    assign tx_ready = (count_q < DEPTH_C);
    assign push     = tx_valid && tx_ready;
    assign head     = mem_q[rd_ptr_q];

    // The FSM takes the head in IDLE, or at the last stop-bit tick so the
    // next frame's start bit follows with no gap.
    assign pop = (count_q != '0) &&
                 ((state_q == IDLE) ||
                  (state_q == STOP && bit_tick && stop_idx_q == STOP_LAST));

    // NOTE: storage has no reset; validity is tracked by the pointers and
    // count, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // NOTE: count_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are PW bits wide, so increments wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------- bit timer
    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (pop),
        .enable   (state_q != IDLE),
        .bit_tick (bit_tick)
    );

    // ----------------------------------------------------------------- FSM
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_idx_q;
    logic                 par_q;
    logic                 txd_q;

    // The enum literal PARITY is shadowed by the parameter of the same name,
    // so the state is referenced through the package.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, whatever the statement order.
    // txd_q is loaded with the level of the bit being entered, so the line
    // changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            txd_q      <= 1'b1;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= head;
                        par_q   <= parity_of(head);
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx_q == LAST_BIT) begin
                            if (PARITY != PAR_NONE) begin
                                txd_q   <= par_q;
                                state_q <= uart_pkg::PARITY;
                            end else begin
                                stop_idx_q <= 1'b0;
                                txd_q      <= 1'b1;
                                state_q    <= STOP;
                            end
                        end else begin
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[1];
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (bit_tick) begin
                        stop_idx_q <= 1'b0;
                        txd_q      <= 1'b1;
                        state_q    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (stop_idx_q == STOP_LAST) begin
                            if (pop) begin
                                shift_q <= head;
                                par_q   <= parity_of(head);
                                txd_q   <= 1'b0;
                                state_q <= START;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txd        = txd_q;
    assign tx_busy    = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Five transmitter configurations (all DIV = 10) share one clock:
//   0: 8N1 depth 16   1: 8E1   2: 8O1   3: 8N1 depth 4   4: 5N2
// Stimulus pushes hand-computed line frames into a scoreboard queue; a
// per-instance monitor decodes txd, pops the queue and compares bits,
// bit lengths and start cycles.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int N   = 5;
    localparam int DIV = 10;

    typedef struct {
        int          id;
        logic [15:0] bits;   // line bits, first bit on the line in bit 0
        int          nbits;
        int          start;  // expected first cycle of the start bit
        int          mode;   // 0: exact start cycle, 1: back-to-back
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn    [N];
    logic       valid   [N];
    logic [7:0] data_r  [N];
    logic       ready_w [N];
    logic       txd_w   [N];
    logic       busy_w  [N];
    logic [7:0] cnt_all [N];
    logic       mon_en  [N];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int DB  = (g == 4) ? 5 : 8;
        localparam int PAR = (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int SB  = (g == 4) ? 2 : 1;
        localparam int DEP = (g == 3) ? 4 : 16;

        logic [$clog2(DEP):0] cnt_w;

        uart_tx_fifo #(
            .CLK_FREQ   (10_000_000),
            .BAUD       (1_000_000),
            .DATA_BITS  (DB),
            .PARITY     (PAR),
            .STOP_BITS  (SB),
            .FIFO_DEPTH (DEP)
        ) dut (
            .clk        (clk),
            .rst_n      (rstn[g]),
            .tx_valid   (valid[g]),
            .tx_data    (data_r[g][DB-1:0]),
            .tx_ready   (ready_w[g]),
            .txd        (txd_w[g]),
            .tx_busy    (busy_w[g]),
            .fifo_count (cnt_w)
        );

        assign cnt_all[g] = 8'(cnt_w);

        // Monitor: a low txd on a falling clock edge is the first cycle of a
        // start bit; every cycle of every bit is sampled.
        initial begin : mon
            int          start_c;
            int          prev_end;
            logic [15:0] bits;
            int          stable;
            exp_t        e;
            prev_end = -1;
            forever begin
                @(negedge clk);
                if (mon_en[g] && txd_w[g] === 1'b0) begin
                    start_c = cyc;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected frame: instance %0d started a frame at cycle %0d, none expected",
                                 g, start_c);
                        repeat (10 * DIV) @(negedge clk);
                    end else begin
                        e      = exp_q.pop_front();
                        bits   = '0;
                        stable = 1;
                        for (int b = 0; b < e.nbits; b++) begin
                            for (int c = 0; c < DIV; c++) begin
                                if (b != 0 || c != 0) @(negedge clk);
                                if (c == 0) bits[b] = txd_w[g];
                                else if (txd_w[g] !== bits[b]) stable = 0;
                            end
                        end
                        check("frame source", g, e.id);
                        check("frame bits", int'(bits), int'(e.bits));
                        check("bit length", stable, 1);
                        if (e.mode == 0) check("start cycle", start_c, e.start);
                        else             check("back-to-back start", start_c, prev_end);
                        prev_end = start_c + e.nbits * DIV;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic write1(input int g, input logic [7:0] d, output int acc);
        valid[g]  = 1'b1;
        data_r[g] = d;
        @(negedge clk);
        acc      = cyc;
        valid[g] = 1'b0;
    endtask

    task automatic push_exp(input int id, input logic [15:0] bits, input int nbits,
                            input int start, input int mode);
        exp_t e;
        e.id = id; e.bits = bits; e.nbits = nbits; e.start = start; e.mode = mode;
        exp_q.push_back(e);
    endtask

    // Called right after write1 returns; busy must last exactly len cycles
    // past the first start-bit cycle.
    task automatic frame_len_check(input int g, input int len);
        repeat (len) @(negedge clk);
        check("busy at frame end", int'(busy_w[g]), 1);
        @(negedge clk);
        check("busy after frame", int'(busy_w[g]), 0);
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n = 0;
        while (busy_w[g] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle within budget", int'(n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        int acc, acc0, bad_txd, bad_busy;
        // cycle-by-cycle fifo_count before each edge of the depth-4 burst
        int fill_cnt [6] = '{0, 1, 1, 2, 3, 4};

        for (int g = 0; g < N; g++) begin
            rstn[g] = 1'b0; valid[g] = 1'b0; data_r[g] = '0; mon_en[g] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) rstn[g] = 1'b1;

        for (int g = 0; g < N; g++) begin
            check("reset txd", int'(txd_w[g]), 1);
            check("reset tx_ready", int'(ready_w[g]), 1);
            check("reset tx_busy", int'(busy_w[g]), 0);
            check("reset fifo_count", int'(cnt_all[g]), 0);
        end

        // 8N1 0xA5: 0 | 1,0,1,0,0,1,0,1 | 1
        write1(0, 8'hA5, acc);
        push_exp(0, 16'h034A, 10, acc + 1, 0);
        frame_len_check(0, 100);
        wait_idle(0, 200);

        // 0x00 then 0xFF, second frame must follow with no gap
        write1(0, 8'h00, acc);
        push_exp(0, 16'h0200, 10, acc + 1, 0);
        write1(0, 8'hFF, acc);
        push_exp(0, 16'h03FE, 10, 0, 1);
        wait_idle(0, 400);

        // 0x07 even parity: parity bit 1, 11-bit frame
        write1(1, 8'h07, acc);
        push_exp(1, 16'h060E, 11, acc + 1, 0);
        frame_len_check(1, 110);
        wait_idle(1, 200);

        // 0x07 odd parity: parity bit 0
        write1(2, 8'h07, acc);
        push_exp(2, 16'h040E, 11, acc + 1, 0);
        frame_len_check(2, 110);
        wait_idle(2, 200);

        // depth 4: six back-to-back writes, the sixth hits a full FIFO
        for (int i = 0; i < 6; i++) begin
            check("burst fifo_count", int'(cnt_all[3]), fill_cnt[i]);
            check("burst tx_ready", int'(ready_w[3]), (i < 5) ? 1 : 0);
            write1(3, 8'(i + 1), acc);
            if (i == 0)     push_exp(3, 16'h0200 | 16'((i + 1) << 1), 10, acc + 1, 0);
            else if (i < 5) push_exp(3, 16'h0200 | 16'((i + 1) << 1), 10, 0, 1);
        end
        wait_idle(3, 1000);
        check("burst drained fifo_count", int'(cnt_all[3]), 0);

        // 5N2: 0x1F -> 0,1,1,1,1,1,1,1 ; 0x0A -> 0,0,1,0,1,0,1,1
        write1(4, 8'h1F, acc);
        push_exp(4, 16'h00FE, 8, acc + 1, 0);
        write1(4, 8'h0A, acc);
        push_exp(4, 16'h00D4, 8, 0, 1);
        wait_idle(4, 400);

        // Reset during data bit 3 of 0x55 with two words still queued
        mon_en[0] = 1'b0;
        write1(0, 8'h55, acc0);
        write1(0, 8'h33, acc);
        write1(0, 8'h0F, acc);
        check("queued before reset", int'(cnt_all[0]), 2);
        repeat (43) @(negedge clk);
        check("data bit 3 of 0x55", int'(txd_w[0]), 0);
        rstn[0] = 1'b0;
        @(negedge clk);
        rstn[0] = 1'b1;
        check("abort txd", int'(txd_w[0]), 1);
        check("abort fifo_count", int'(cnt_all[0]), 0);
        check("abort tx_ready", int'(ready_w[0]), 1);
        check("abort tx_busy", int'(busy_w[0]), 0);

        // No writes for 1000 cycles: line stays idle
        bad_txd  = 0;
        bad_busy = 0;
        repeat (1000) begin
            @(negedge clk);
            if (txd_w[0] !== 1'b1) bad_txd++;
            if (busy_w[0] !== 1'b0) bad_busy++;
        end
        check("idle cycles with txd low", bad_txd, 0);
        check("idle cycles with busy", bad_busy, 0);

        check("frames left unsent", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
